// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline controller slice: FSM state encodings,
// the register-index width used by the hazard compare, the default memory
// timeout and a small helper for the taken-branch condition.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    localparam int REG_IDX_W        = 5;
    localparam int WAIT_MAX_DEFAULT = 255;

    // A branch sitting in EXE/MEM is taken when its zero flag is set.
    function automatic logic branch_taken(input logic branch, input logic zero);
        return branch & zero;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect
// Purely combinational load-use compare: flags when the instruction in EXE is
// a load whose destination (non-zero) is read by the instruction in ID.
// Ports:
//   ex_memtoreg  in   EXE instruction is a load
//   ex_rd        in   EXE destination register
//   id_rs/id_rt  in   ID source register fields
//   load_use     out  stall required
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic                 ex_memtoreg,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    output logic                 load_use
);

    logic [1:0][REG_IDX_W-1:0] src;
    logic [1:0]                match;

    assign src = {id_rt, id_rs};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign match[gi] = (src[gi] == ex_rd);
        end
    endgenerate

    // r0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign load_use = ex_memtoreg && (ex_rd != '0) && (|match);

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Stall/flush controller for a 5-stage pipeline. Resolves load-use hazards,
// taken branches and multi-cycle data-memory accesses, with a timeout that
// parks the controller in a sticky ERROR state.
// Ports:
//   clk, rst (async, active-low)
//   id_rs, id_rt, ex_memtoreg, ex_rd     hazard inputs
//   mem_branch, mem_zero                 branch resolution in EXE/MEM
//   mem_access, dmem_ack, dmem_req       data-memory handshake
//   pc_en, *_en                          pipeline register enables
//   *_flush, pc_src                      flush and PC select
//   err, ctrl_state, stall_cnt           status / debug
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 ex_memtoreg,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 mem_branch,
    input  logic                 mem_zero,
    input  logic                 mem_access,
    input  logic                 dmem_ack,
    output logic                 dmem_req,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 pc_src,
    output logic                 err,
    output logic [1:0]           ctrl_state,
    output logic [15:0]          stall_cnt
);

    // The counter reaches WAIT_MAX on the edge after this value is seen.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    ctrl_state_t state_reg;
    logic [7:0]  wait_cnt_reg;
    logic [15:0] stall_cnt_reg;
    logic        err_reg;
    logic        load_use;
    logic        br_taken;

    hazard_detect u_hazard_detect (
        .ex_memtoreg (ex_memtoreg),
        .ex_rd       (ex_rd),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .load_use    (load_use)
    );

    assign br_taken = branch_taken(mem_branch, mem_zero);

    // Output priority mux. Everything is gated by rst so the pipeline is
    // frozen and memory is released the instant reset asserts.
    always_comb begin
        dmem_req     = 1'b0;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_src       = 1'b0;
        if (rst) begin
            case (state_reg)
                RUN: begin
                    dmem_req = mem_access;
                    // Memory stall outranks branch and load-use: freeze all.
                    if (!(mem_access && !dmem_ack)) begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                        if (br_taken) begin
                            pc_src       = 1'b1;
                            if_id_flush  = 1'b1;
                            id_ex_flush  = 1'b1;
                            ex_mem_flush = 1'b1;
                        end else if (load_use) begin
                            pc_en       = 1'b0;
                            if_id_en    = 1'b0;
                            id_ex_flush = 1'b1;
                        end
                    end
                end
                MEM_WAIT: begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RUN;
            wait_cnt_reg  <= '0;
            stall_cnt_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            if (!pc_en && (stall_cnt_reg != 16'hFFFF))
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            case (state_reg)
                RUN: begin
                    if (mem_access && !dmem_ack) begin
                        state_reg    <= MEM_WAIT;
                        wait_cnt_reg <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) begin
                        state_reg <= RUN;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        if (wait_cnt_reg == WAIT_LAST) begin
                            state_reg <= ERROR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                ERROR: ;
                default: state_reg <= RUN;
            endcase
        end
    end

    assign ctrl_state = state_reg;
    assign stall_cnt  = stall_cnt_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
    logic        ex_memtoreg = 1'b0, mem_branch = 1'b0, mem_zero = 1'b0;
    logic        mem_access = 1'b0, dmem_ack = 1'b0;
    logic        dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, pc_src, err;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt;
    logic [10:0] outs;

    int checks = 0;
    int errors = 0;

    // {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    //  if_id_flush, id_ex_flush, ex_mem_flush, pc_src, err}
    localparam logic [10:0] O_ZERO   = 11'b0_00000_000_0_0;
    localparam logic [10:0] O_IDLE   = 11'b0_11111_000_0_0;
    localparam logic [10:0] O_LU     = 11'b0_00111_010_0_0;
    localparam logic [10:0] O_BR     = 11'b0_11111_111_1_0;
    localparam logic [10:0] O_MSTALL = 11'b1_00000_000_0_0;
    localparam logic [10:0] O_MACK   = 11'b1_11111_000_0_0;
    localparam logic [10:0] O_ERR    = 11'b0_00000_000_0_1;

    assign outs = {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, ex_mem_flush, pc_src, err};

    pipeline_ctrl #(.WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memtoreg(ex_memtoreg), .ex_rd(ex_rd), .mem_branch(mem_branch),
        .mem_zero(mem_zero), .mem_access(mem_access), .dmem_ack(dmem_ack),
        .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .pc_src(pc_src), .err(err),
        .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0; ex_memtoreg = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0; mem_access = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves us 2 time units after a rising edge, reset released mid-cycle.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_access = 1'b1; ex_memtoreg = 1'b1; ex_rd = 5'd3; id_rs = 5'd3;
        mem_branch = 1'b1; mem_zero = 1'b1;
        #2;
        checks++;
        if (outs !== O_ZERO) begin
            errors++; $display("FAIL reset_outs: got %b expected %b", outs, O_ZERO);
        end
        tick();
        checks++;
        if (outs !== O_ZERO || ctrl_state !== 2'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_held: outs %b state %0d stall %0d expected %b 0 0",
                     outs, ctrl_state, stall_cnt, O_ZERO);
        end
        idle_inputs();
        #2 rst = 1'b1;
        tick();
        checks++;
        if (outs !== O_IDLE || ctrl_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_release: outs %b state %0d expected %b 0", outs, ctrl_state, O_IDLE);
        end
        $display("test_reset: outs=%b state=%0d", outs, ctrl_state);
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memtoreg = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_rs = 5'd3;
        #1;
        checks++;
        if (outs !== O_LU) begin
            errors++; $display("FAIL load_use_rt: got %b expected %b", outs, O_LU);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (stall_cnt !== 16'd1 || outs !== O_IDLE) begin
            errors++;
            $display("FAIL load_use_bubble: stall %0d outs %b expected 1 %b", stall_cnt, outs, O_IDLE);
        end
        ex_memtoreg = 1'b1; ex_rd = 5'd7; id_rs = 5'd7; id_rt = 5'd2;
        #1;
        checks++;
        if (outs !== O_LU) begin
            errors++; $display("FAIL load_use_rs: got %b expected %b", outs, O_LU);
        end
        ex_memtoreg = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++; $display("FAIL no_load_match: got %b expected %b", outs, O_IDLE);
        end
        $display("test_load_use: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_rd_zero();
        idle_inputs();
        ex_memtoreg = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd9;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++; $display("FAIL rd_zero: got %b expected %b", outs, O_IDLE);
        end
        $display("test_rd_zero: outs=%b", outs);
    endtask

    task automatic test_branch_hazard();
        do_reset();
        ex_memtoreg = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
        mem_branch = 1'b1; mem_zero = 1'b1;
        #1;
        checks++;
        if (outs !== O_BR) begin
            errors++; $display("FAIL branch_wins: got %b expected %b", outs, O_BR);
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++; $display("FAIL branch_no_stall: got %0d expected 0", stall_cnt);
        end
        mem_zero = 1'b0;
        #1;
        checks++;
        if (outs !== O_LU) begin
            errors++; $display("FAIL branch_not_taken: got %b expected %b", outs, O_LU);
        end
        $display("test_branch_hazard: outs=%b", outs);
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_access = 1'b1; dmem_ack = 1'b1;
        #1;
        checks++;
        if (outs !== O_MACK) begin
            errors++; $display("FAIL mem_zero_wait: got %b expected %b", outs, O_MACK);
        end
        tick();
        dmem_ack = 1'b0; mem_branch = 1'b1; mem_zero = 1'b1;
        #1;
        checks++;
        if (outs !== O_MSTALL || ctrl_state !== 2'd0 || stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mem_stall_prio: outs %b state %0d stall %0d expected %b 0 0",
                     outs, ctrl_state, stall_cnt, O_MSTALL);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_branch = 1'b0; mem_zero = 1'b0;
            if (i == 2) dmem_ack = 1'b1;
            #1;
            checks++;
            if (ctrl_state !== 2'd1 || outs !== ((i == 2) ? O_MACK : O_MSTALL)) begin
                errors++;
                $display("FAIL mem_wait_cycle%0d: state %0d outs %b expected 1 %b",
                         i, ctrl_state, outs, (i == 2) ? O_MACK : O_MSTALL);
            end
        end
        tick();
        mem_access = 1'b0;
        #1;
        checks++;
        if (ctrl_state !== 2'd0 || stall_cnt !== 16'd3 || outs !== O_IDLE) begin
            errors++;
            $display("FAIL mem_wait_done: state %0d stall %0d outs %b expected 0 3 %b",
                     ctrl_state, stall_cnt, outs, O_IDLE);
        end
        tick();
        checks++;
        if (ctrl_state !== 2'd0 || outs !== O_IDLE) begin
            errors++;
            $display("FAIL ack_ignored: state %0d outs %b expected 0 %b", ctrl_state, outs, O_IDLE);
        end
        $display("test_mem_wait: stall_cnt=%0d", stall_cnt);
    endtask

    task automatic test_timeout();
        do_reset();
        mem_access = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (ctrl_state !== 2'd1) begin
            errors++; $display("FAIL timeout_waiting: state %0d expected 1", ctrl_state);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (ctrl_state !== 2'd2 || outs !== O_ERR) begin
            errors++;
            $display("FAIL timeout_error: state %0d outs %b expected 2 %b", ctrl_state, outs, O_ERR);
        end
        dmem_ack = 1'b1;
        tick();
        checks++;
        if (ctrl_state !== 2'd2 || outs !== O_ERR || stall_cnt !== 16'd9) begin
            errors++;
            $display("FAIL error_sticky: state %0d outs %b stall %0d expected 2 %b 9",
                     ctrl_state, outs, stall_cnt, O_ERR);
        end
        $display("test_timeout: state=%0d err=%b", ctrl_state, err);
    endtask

    task automatic test_async_reset();
        do_reset();
        mem_access = 1'b1;
        tick();
        tick();
        checks++;
        if (ctrl_state !== 2'd1 || dmem_req !== 1'b1 || stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL pre_reset_wait: state %0d req %b stall %0d expected 1 1 2",
                     ctrl_state, dmem_req, stall_cnt);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || ctrl_state !== 2'd0 || stall_cnt !== 16'd0 || outs !== O_ZERO) begin
            errors++;
            $display("FAIL async_reset: req %b state %0d stall %0d outs %b expected 0 0 0 %b",
                     dmem_req, ctrl_state, stall_cnt, outs, O_ZERO);
        end
        idle_inputs();
        #1 rst = 1'b1;
        tick();
        checks++;
        if (outs !== O_IDLE || ctrl_state !== 2'd0) begin
            errors++;
            $display("FAIL post_reset: outs %b state %0d expected %b 0", outs, ctrl_state, O_IDLE);
        end
        $display("test_async_reset: state=%0d", ctrl_state);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_branch_hazard();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- ex_memtoreg  in  1  the instruction in EXE is a load.
- ex_rd  in  5  destination register of the instruction in EXE.
- mem_branch  in  1  the EXE/MEM register holds a branch.
- mem_zero  in  1  the EXE/MEM register holds zero = 1.
- mem_access  in  1  the instruction in MEM reads or writes data memory.
- dmem_ack  in  1  data memory completes the current access.
- dmem_req  out  1  data memory access request.
- pc_en  out  1  PC load enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EXE register enable.
- ex_mem_en  out  1  EXE/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  zero IF/ID next edge.
- id_ex_flush  out  1  zero ID/EXE next edge.
- ex_mem_flush  out  1  zero EXE/MEM next edge.
- pc_src  out  1  select branch target for PC.
- err  out  1  sticky memory-timeout error.
- ctrl_state  out  2  current FSM state, for debug.
- stall_cnt  out  16  saturating count of cycles with pc_en = 0.

REQ-002 Parameter WAIT_MAX, default 255: maximum MEM_WAIT cycles before timeout.

Function
REQ-003 The FSM SHALL have three states, encoded RUN = 0, MEM_WAIT = 1, ERROR = 2.

REQ-004 Defaults in RUN, when no condition applies:
- all enables = 1;
- all flushes = 0;
- pc_src = 0;
- dmem_req = mem_access.

REQ-005 Load-use hazard:
- Condition: ex_memtoreg = 1, ex_rd != 0, and ex_rd equals id_rs or id_rt.
- Response, same cycle (combinational): pc_en = 0, if_id_en = 0, id_ex_flush = 1.
- Net effect: a one-cycle bubble.

REQ-006 Taken branch:
- Condition: in RUN, mem_branch = 1 and mem_zero = 1.
- Response, same cycle: pc_src = 1, if_id_flush = 1, id_ex_flush = 1, ex_mem_flush = 1.
- The load-use stall is suppressed in that cycle (the branch wins).

REQ-007 Memory access:
- In RUN, mem_access = 1 with dmem_ack = 1 in the same cycle completes with zero stall.
- In RUN, mem_access = 1 with dmem_ack = 0: go to MEM_WAIT next edge, and all enables = 0 in that cycle.
- The memory stall has priority over the branch and load-use responses; flushes = 0 and pc_src = 0 while it applies.

REQ-008 MEM_WAIT:
- dmem_req = 1; all enables = 0; all flushes = 0.
- On dmem_ack = 1: all enables = 1 in that cycle, and the FSM goes to RUN next edge.
- The branch and load-use conditions are re-evaluated only in RUN.

REQ-009 Wait counter:
- 8-bit, cleared on entry to MEM_WAIT, increments each MEM_WAIT cycle without ack.
- When it reaches WAIT_MAX without ack, the FSM goes to ERROR next edge.

REQ-010 ERROR:
- All enables = 0, dmem_req = 0, err = 1.
- The state is held until reset; dmem_ack is ignored.

REQ-011 stall_cnt:
- Increments on each edge where pc_en = 0.
- Saturates at 0xFFFF with no wrap.

REQ-012 A dmem_ack while mem_access = 0 in RUN SHALL be ignored.

Reset
REQ-013 While rst = 0, all of the following SHALL hold:
- state = RUN; wait counter = 0; stall_cnt = 0; err = 0;
- all enables = 0, all flushes = 0, pc_src = 0, dmem_req = 0.
- These values apply regardless of the clock.

REQ-014 The first rising clk edge after rst rises SHALL see the REQ-004 defaults.

REQ-015 Reset asserted mid-MEM_WAIT SHALL abandon the access (dmem_req = 0 immediately).

Structure
REQ-016 The shared package SHALL hold:
- the state encodings RUN, MEM_WAIT, ERROR;
- the 5-bit register-index width;
- the WAIT_MAX default.

REQ-017 A single sub-module, hazard_detect, SHALL hold the purely combinational load-use compare.
- The FSM, counters and output priority mux stay in pipeline_ctrl.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Load-use: ex_memtoreg = 1, ex_rd = 5, id_rt = 5 -> pc_en = 0, if_id_en = 0, id_ex_flush = 1 for one cycle; stall_cnt = 1.
- ex_rd = 0: ex_memtoreg = 1, ex_rd = 0, id_rs = 0 -> no stall; all enables = 1.
- Branch with hazard: mem_branch = 1, mem_zero = 1 while a load-use hazard is present -> pc_src = 1, three flushes = 1, pc_en = 1.
- Memory wait: mem_access = 1, ack after 3 cycles -> ctrl_state = 1 for 3 cycles, all enables = 0, dmem_req = 1, then RUN; stall_cnt = 3.
- Timeout: mem_access = 1, no ack, WAIT_MAX = 4 -> ctrl_state = 2 and err = 1 after timeout; a later ack has no effect.
- Async reset: rst = 0 mid-MEM_WAIT between clock edges -> dmem_req = 0, ctrl_state = 0, stall_cnt = 0 immediately.
